// File: rtl/dense_axis_buffer.sv
// Stream-side buffer for the dense layer: captures one AXIS input frame into
// an addressable input buffer, collects datapath results into an output
// buffer, and replays them as one AXIS master frame.
module dense_axis_buffer #(
    parameter int unsigned IN_COUNT      = 1600,
    parameter int unsigned OUT_COUNT     = 10,
    parameter int unsigned DATA_SIZE     = 32,
    parameter int unsigned IN_ADR_WIDTH  = 11,
    parameter int unsigned OUT_ADR_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_SIZE-1:0]     s_axis_tdata,
    input  logic                     s_axis_tvalid,
    input  logic                     s_axis_tlast,
    output logic                     s_axis_tready,
    output logic [DATA_SIZE-1:0]     m_axis_tdata,
    output logic                     m_axis_tvalid,
    output logic                     m_axis_tlast,
    input  logic                     m_axis_tready,
    input  logic [IN_ADR_WIDTH-1:0]  bufferIn_adr,
    output logic [DATA_SIZE-1:0]     bufferIn_data,
    input  logic [OUT_ADR_WIDTH-1:0] bufferOut_adr,
    input  logic [DATA_SIZE-1:0]     bufferOut_data,
    input  logic                     bufferOut_wr,
    output logic                     gotData,
    input  logic                     putData,
    output logic                     frameErr
);

    typedef enum logic [1:0] {RECV, WAIT, SEND} stateType;

    localparam logic [IN_ADR_WIDTH-1:0]  LAST_IN   = IN_ADR_WIDTH'(IN_COUNT - 1);
    localparam logic [OUT_ADR_WIDTH-1:0] LAST_OUT  = OUT_ADR_WIDTH'(OUT_COUNT - 1);
    localparam logic [IN_ADR_WIDTH:0]    IN_LIMIT  = (IN_ADR_WIDTH + 1)'(IN_COUNT);
    localparam logic [OUT_ADR_WIDTH:0]   OUT_LIMIT = (OUT_ADR_WIDTH + 1)'(OUT_COUNT);

    logic [DATA_SIZE-1:0] inBuf  [IN_COUNT];
    logic [DATA_SIZE-1:0] outBuf [OUT_COUNT];

    stateType                 state, stateNext;
    logic [IN_ADR_WIDTH-1:0]  wrPtr, wrPtrNext;
    logic [OUT_ADR_WIDTH-1:0] rdPtr, rdPtrNext, rdPtrInc;
    logic                     treadyNext;
    logic                     mValidNext, mLastNext;
    logic [DATA_SIZE-1:0]     mDataNext;
    logic                     gotDataNext, frameErrNext;
    logic                     inWr, outWr, inAccept;

    assign inAccept = (state == RECV) && s_axis_tvalid && s_axis_tready;
    assign rdPtrInc = rdPtr + OUT_ADR_WIDTH'(1);

    // Combinational read port for the datapath; out-of-range addresses read zero.
    assign bufferIn_data = ({1'b0, bufferIn_adr} < IN_LIMIT) ? inBuf[bufferIn_adr] : '0;

    // State and registered-output update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= RECV;
            wrPtr         <= '0;
            rdPtr         <= '0;
            s_axis_tready <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
            gotData       <= 1'b0;
            frameErr      <= 1'b0;
        end else begin
            state         <= stateNext;
            wrPtr         <= wrPtrNext;
            rdPtr         <= rdPtrNext;
            s_axis_tready <= treadyNext;
            m_axis_tvalid <= mValidNext;
            m_axis_tlast  <= mLastNext;
            m_axis_tdata  <= mDataNext;
            gotData       <= gotDataNext;
            frameErr      <= frameErrNext;
        end
    end

    // Buffer storage writes; contents survive reset.
    always_ff @(posedge clk) begin
        if (inWr) begin
            inBuf[wrPtr] <= s_axis_tdata;
        end
        if (outWr) begin
            outBuf[bufferOut_adr] <= bufferOut_data;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        stateNext    = state;
        wrPtrNext    = wrPtr;
        rdPtrNext    = rdPtr;
        mValidNext   = m_axis_tvalid;
        mLastNext    = m_axis_tlast;
        mDataNext    = m_axis_tdata;
        gotDataNext  = 1'b0;
        frameErrNext = frameErr;
        inWr         = 1'b0;
        outWr        = 1'b0;
        treadyNext   = 1'b0;

        case (state)
            RECV: begin
                if (inAccept) begin
                    inWr = 1'b1;
                    if (wrPtr == LAST_IN) begin
                        // Final counted beat closes the frame even if tlast is missing.
                        wrPtrNext   = '0;
                        stateNext   = WAIT;
                        gotDataNext = 1'b1;
                        if (!s_axis_tlast) begin
                            frameErrNext = 1'b1;
                        end
                    end else if (s_axis_tlast) begin
                        // Short frame: drop it and restart counting.
                        wrPtrNext    = '0;
                        frameErrNext = 1'b1;
                    end else begin
                        wrPtrNext = wrPtr + IN_ADR_WIDTH'(1);
                    end
                end
            end

            WAIT: begin
                outWr = bufferOut_wr && ({1'b0, bufferOut_adr} < OUT_LIMIT);
                if (putData) begin
                    stateNext = SEND;
                    rdPtrNext = '0;
                end
            end

            SEND: begin
                if (!m_axis_tvalid) begin
                    // First beat is loaded one cycle after entry so a write
                    // coinciding with putData is already in the buffer.
                    mValidNext = 1'b1;
                    mDataNext  = outBuf[rdPtr];
                    mLastNext  = (rdPtr == LAST_OUT);
                end else if (m_axis_tready) begin
                    if (m_axis_tlast) begin
                        mValidNext = 1'b0;
                        mLastNext  = 1'b0;
                        stateNext  = RECV;
                    end else begin
                        rdPtrNext = rdPtrInc;
                        mDataNext = outBuf[rdPtrInc];
                        mLastNext = (rdPtrInc == LAST_OUT);
                    end
                end
            end

            default: begin
                stateNext = RECV;
            end
        endcase

        treadyNext = (stateNext == RECV);
    end

endmodule

// File: tb/tb_dense_axis_buffer.sv
// Directed bench for dense_axis_buffer: a frame/queue level model is checked
// against the DUT every cycle, plus hand-computed literal expectations.
module tb_dense_axis_buffer;

    localparam int IN_COUNT  = 1600;
    localparam int OUT_COUNT = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_tdata;
    logic        s_tvalid, s_tlast, s_tready;
    logic [31:0] m_tdata;
    logic        m_tvalid, m_tlast, m_tready;
    logic [10:0] inAdr;
    logic [31:0] inData;
    logic [3:0]  outAdr;
    logic [31:0] outData;
    logic        outWr, gotData, putData, frameErr;

    int nCmp = 0;
    int nErr = 0;
    int gotCount = 0;

    dense_axis_buffer dut (
        .clk            (clk),
        .rst            (rst),
        .s_axis_tdata   (s_tdata),
        .s_axis_tvalid  (s_tvalid),
        .s_axis_tlast   (s_tlast),
        .s_axis_tready  (s_tready),
        .m_axis_tdata   (m_tdata),
        .m_axis_tvalid  (m_tvalid),
        .m_axis_tlast   (m_tlast),
        .m_axis_tready  (m_tready),
        .bufferIn_adr   (inAdr),
        .bufferIn_data  (inData),
        .bufferOut_adr  (outAdr),
        .bufferOut_data (outData),
        .bufferOut_wr   (outWr),
        .gotData        (gotData),
        .putData        (putData),
        .frameErr       (frameErr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          mPhase;      // 0 receiving, 1 waiting for results, 2 sending
    bit          mReady, mGot, mErr, mValid, mLast;
    int          mCount;
    logic [31:0] mData;
    logic [31:0] mIn [IN_COUNT];
    bit          known [IN_COUNT];
    logic [31:0] mOut [OUT_COUNT];
    logic [31:0] sendQ [$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mPhase = 0; mReady = 0; mCount = 0; mGot = 0; mErr = 0;
            mValid = 0; mLast = 0; mData = '0;
            sendQ.delete();
        end else begin
            mGot = 0;
            case (mPhase)
                0: if (mReady && s_tvalid) begin
                    mIn[mCount]   = s_tdata;
                    known[mCount] = 1'b1;
                    if (mCount == IN_COUNT - 1) begin
                        if (!s_tlast) mErr = 1;
                        mCount = 0; mPhase = 1; mGot = 1;
                    end else if (s_tlast) begin
                        mErr = 1; mCount = 0;
                    end else begin
                        mCount++;
                    end
                end
                1: begin
                    if (outWr && outAdr < OUT_COUNT) mOut[outAdr] = outData;
                    if (putData) begin
                        sendQ.delete();
                        for (int k = 0; k < OUT_COUNT; k++) sendQ.push_back(mOut[k]);
                        mPhase = 2;
                    end
                end
                default: begin
                    if (!mValid) begin
                        mValid = 1; mData = sendQ[0]; mLast = (sendQ.size() == 1);
                    end else if (m_tready) begin
                        void'(sendQ.pop_front());
                        if (sendQ.size() == 0) begin
                            mValid = 0; mLast = 0; mPhase = 0;
                        end else begin
                            mData = sendQ[0]; mLast = (sendQ.size() == 1);
                        end
                    end
                end
            endcase
            mReady = (mPhase == 0);
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("tready", {31'b0, s_tready}, {31'b0, mReady});
        chk("gotData", {31'b0, gotData}, {31'b0, mGot});
        chk("frameErr", {31'b0, frameErr}, {31'b0, mErr});
        chk("mValid", {31'b0, m_tvalid}, {31'b0, mValid});
        if (mValid) begin
            chk("mData", m_tdata, mData);
            chk("mLast", {31'b0, m_tlast}, {31'b0, mLast});
        end
        if (inAdr >= 11'(IN_COUNT)) chk("inReadOor", inData, 32'd0);
        else if (known[inAdr]) chk("inRead", inData, mIn[inAdr]);
    end

    // Observers: gotData pulses and output handshakes.
    logic [31:0] colData [$];
    bit          colLast [$];
    always @(negedge clk) begin
        if (gotData === 1'b1) gotCount++;
        if (m_tvalid && m_tready) begin
            colData.push_back(m_tdata);
            colLast.push_back(m_tlast);
        end
    end

    // Drive n beats of base+i, tlast on index lastAt, optional random tvalid gaps.
    task automatic streamFrame(input int n, input int lastAt, input int base, input bit gaps);
        int i = 0;
        int guard = 0;
        bit acc;
        while (i < n) begin
            s_tvalid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            s_tdata  = 32'(base + i);
            s_tlast  = (i == lastAt);
            @(negedge clk);
            acc = s_tvalid && s_tready;
            @(posedge clk); #1;
            if (acc) i++;
            guard++;
            if (guard > 20000) begin
                chk("streamTimeout", 32'(i), 32'(n));
                break;
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic readIn(input int adr, input logic [31:0] exp, input string name);
        inAdr = 11'(adr);
        #1;
        chk(name, inData, exp);
    endtask

    task automatic cycle();
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr + 1);
        $fatal(1);
    end

    initial begin
        bit stalled;
        int gotBefore;
        rst = 1'b1;
        s_tdata = '0; s_tvalid = 0; s_tlast = 0;
        m_tready = 0; inAdr = '0; outAdr = '0; outData = '0; outWr = 0; putData = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rstTready", {31'b0, s_tready}, 32'd0);
        chk("rstValid", {31'b0, m_tvalid}, 32'd0);
        chk("rstGot", {31'b0, gotData}, 32'd0);
        chk("rstErr", {31'b0, frameErr}, 32'd0);
        chk("rstData", m_tdata, 32'd0);
        rst = 1'b0;
        cycle();
        chk("readyAfterRst", {31'b0, s_tready}, 32'd1);

        // Full frame, continuous valid.
        streamFrame(IN_COUNT, IN_COUNT - 1, 0, 1'b0);
        chk("gotPulseNow", {31'b0, gotData}, 32'd1);
        chk("readyDropped", {31'b0, s_tready}, 32'd0);
        cycle(); cycle();
        chk("gotCount1", 32'(gotCount), 32'd1);
        chk("errAfterA", {31'b0, frameErr}, 32'd0);
        readIn(0, 32'd0, "rdA0");
        readIn(799, 32'd799, "rdA799");
        readIn(1599, 32'd1599, "rdA1599");
        readIn(2000, 32'd0, "rdOor");
        cycle();

        // Results written in WAIT, putData together with the last write.
        m_tready = 1'b1;
        for (int k = 0; k < OUT_COUNT; k++) begin
            outAdr = 4'(k); outData = 32'(100 + k); outWr = 1'b1;
            putData = (k == OUT_COUNT - 1);
            cycle();
        end
        outWr = 1'b0; putData = 1'b0;
        stalled = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (m_tvalid && m_tdata == 32'd103 && !stalled) begin
                stalled = 1'b1;
                m_tready = 1'b0;
                for (int s = 0; s < 4; s++) begin
                    cycle();
                    chk("stallValid", {31'b0, m_tvalid}, 32'd1);
                    chk("stallData", m_tdata, 32'd103);
                end
                m_tready = 1'b1;
            end
            if (colData.size() == OUT_COUNT && !m_tvalid) break;
            cycle();
        end
        chk("outCount", 32'(colData.size()), 32'(OUT_COUNT));
        for (int k = 0; k < colData.size(); k++) begin
            chk("outWord", colData[k], 32'(100 + k));
            chk("outLast", {31'b0, colLast[k]}, {31'b0, k == OUT_COUNT - 1});
        end
        chk("readyAfterSend", {31'b0, s_tready}, 32'd1);

        // Short frame with tlast on beat 5.
        streamFrame(6, 5, 5000, 1'b0);
        cycle();
        chk("shortErr", {31'b0, frameErr}, 32'd1);
        chk("shortNoGot", 32'(gotCount), 32'd1);
        chk("shortReady", {31'b0, s_tready}, 32'd1);

        // Correct frame with random valid gaps overwrites the short one.
        streamFrame(IN_COUNT, IN_COUNT - 1, 10000, 1'b1);
        cycle();
        chk("gotCount2", 32'(gotCount), 32'd2);
        readIn(0, 32'd10000, "rdB0");
        readIn(5, 32'd10005, "rdB5");
        readIn(799, 32'd10799, "rdB799");

        // Drain results back to RECV.
        colData.delete(); colLast.delete();
        putData = 1'b1;
        cycle();
        putData = 1'b0;
        for (int c = 0; c < 100 && !s_tready; c++) cycle();
        chk("drainDone", {31'b0, s_tready}, 32'd1);

        // Reset while beat 800 is on the bus.
        streamFrame(800, -1, 20000, 1'b0);
        s_tvalid = 1'b1; s_tdata = 32'd20800;
        #2 rst = 1'b1;
        #1;
        chk("midRstReady", {31'b0, s_tready}, 32'd0);
        chk("midRstErr", {31'b0, frameErr}, 32'd0);
        chk("midRstValid", {31'b0, m_tvalid}, 32'd0);
        chk("midRstGot", {31'b0, gotData}, 32'd0);
        chk("midRstLast", {31'b0, m_tlast}, 32'd0);
        s_tvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cycle();
        gotBefore = gotCount;
        streamFrame(IN_COUNT, IN_COUNT - 1, 30000, 1'b0);
        cycle();
        chk("gotAfterRst", 32'(gotCount - gotBefore), 32'd1);
        readIn(0, 32'd30000, "rdC0");
        readIn(1599, 32'd31599, "rdC1599");
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
